// File: rtl/mem_access_unit.sv
// Load/store stage: turns an ALU effective address plus store operand into one
// req/ack data-memory transaction and returns the extended load result.
module mem_access_unit #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] alu_out,
   input  logic [31:0] store_data,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic [31:0] load_data,
   output logic        done,
   output logic        busy,
   output logic        err_align,
   output logic        err_timeout
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             is_load_q, is_load_d;
   logic [2:0]       funct3_q, funct3_d;
   logic [1:0]       lane_q, lane_d;
   logic             bus_req_q, bus_req_d;
   logic             bus_we_q, bus_we_d;
   logic [31:0]      bus_addr_q, bus_addr_d;
   logic [31:0]      bus_wdata_q, bus_wdata_d;
   logic [3:0]       bus_wstrb_q, bus_wstrb_d;
   logic [31:0]      load_data_q, load_data_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             err_align_q, err_align_d;
   logic             err_timeout_q, err_timeout_d;

   logic             illegal, misalign;
   logic [7:0]       rd_byte;
   logic [15:0]      rd_half;
   logic [31:0]      rd_ext;

   always_comb begin
      illegal  = mem_write ? (funct3[2] | (funct3[1:0] == 2'b11))
                           : (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
      misalign = ((funct3[1:0] == 2'b01) & alu_out[0]) |
                 ((funct3[1:0] == 2'b10) & (|alu_out[1:0]));

      rd_byte = bus_rdata[8*lane_q +: 8];
      rd_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (funct3_q)
         3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
         3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
         3'b100:  rd_ext = {24'd0, rd_byte};
         3'b101:  rd_ext = {16'd0, rd_half};
         default: rd_ext = bus_rdata;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      is_load_d     = is_load_q;
      funct3_d      = funct3_q;
      lane_d        = lane_q;
      bus_req_d     = 1'b0;
      bus_we_d      = bus_we_q;
      bus_addr_d    = bus_addr_q;
      bus_wdata_d   = bus_wdata_q;
      bus_wstrb_d   = bus_wstrb_q;
      load_data_d   = load_data_q;
      done_d        = 1'b0;
      err_align_d   = 1'b0;
      err_timeout_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (!(mem_read || mem_write)) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else if (illegal || misalign) begin
                  state_d     = DONE;
                  done_d      = 1'b1;
                  err_align_d = 1'b1;
                  is_load_d   = !mem_write;
                  if (!mem_write) load_data_d = 32'd0;
               end else begin
                  state_d     = REQ;
                  bus_req_d   = 1'b1;
                  is_load_d   = !mem_write;
                  funct3_d    = funct3;
                  lane_d      = alu_out[1:0];
                  bus_we_d    = mem_write;
                  bus_addr_d  = {alu_out[31:2], 2'b00};
                  bus_wstrb_d = 4'b0000;
                  bus_wdata_d = 32'd0;
                  if (mem_write) begin
                     case (funct3[1:0])
                        2'b00: begin
                           bus_wstrb_d = 4'b0001 << alu_out[1:0];
                           bus_wdata_d = {4{store_data[7:0]}};
                        end
                        2'b01: begin
                           bus_wstrb_d = 4'b0011 << {alu_out[1], 1'b0};
                           bus_wdata_d = {2{store_data[15:0]}};
                        end
                        default: begin
                           bus_wstrb_d = 4'b1111;
                           bus_wdata_d = store_data;
                        end
                     endcase
                  end
               end
            end
         end
         REQ: begin
            if (bus_ack) begin
               state_d = DONE;
               done_d  = 1'b1;
               cnt_d   = '0;
               if (is_load_q) load_data_d = rd_ext;
            end else if (TO_EN && cnt_q == CNT_LAST) begin
               // Abort: bus_req falls as the state leaves REQ.
               state_d       = DONE;
               done_d        = 1'b1;
               err_timeout_d = 1'b1;
               cnt_d         = '0;
               if (is_load_q) load_data_d = 32'd0;
            end else begin
               cnt_d     = cnt_q + CNT_W'(1);
               bus_req_d = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         is_load_q     <= 1'b0;
         funct3_q      <= 3'd0;
         lane_q        <= 2'd0;
         bus_req_q     <= 1'b0;
         bus_we_q      <= 1'b0;
         bus_addr_q    <= 32'd0;
         bus_wdata_q   <= 32'd0;
         bus_wstrb_q   <= 4'd0;
         load_data_q   <= 32'd0;
         done_q        <= 1'b0;
         busy_q        <= 1'b0;
         err_align_q   <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         is_load_q     <= is_load_d;
         funct3_q      <= funct3_d;
         lane_q        <= lane_d;
         bus_req_q     <= bus_req_d;
         bus_we_q      <= bus_we_d;
         bus_addr_q    <= bus_addr_d;
         bus_wdata_q   <= bus_wdata_d;
         bus_wstrb_q   <= bus_wstrb_d;
         load_data_q   <= load_data_d;
         done_q        <= done_d;
         busy_q        <= busy_d;
         err_align_q   <= err_align_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   assign bus_req     = bus_req_q;
   assign bus_we      = bus_we_q;
   assign bus_addr    = bus_addr_q;
   assign bus_wdata   = bus_wdata_q;
   assign bus_wstrb   = bus_wstrb_q;
   assign load_data   = load_data_q;
   assign done        = done_q;
   assign busy        = busy_q;
   assign err_align   = err_align_q;
   assign err_timeout = err_timeout_q;

endmodule
